// File: rtl/aes128_round_units.sv
`default_nettype none
// ============================================================================
//  Module : aes128_round_units  (file also holds aes128_pkg, keyexpansion,
//           round, lastround)
//  Brief  : AES-128 building blocks: a sequential key expander producing all
//           eleven round keys, a registered middle-round stage, a registered
//           final-round stage, and a top level that exposes one stand-alone
//           instance of each stage plus a complete pipelined cipher chain
//           (AddRoundKey, 9 x round, lastround) fed by the key expander.
//  Ports  : clk, rst (async, active-high)
//           key_i/start_i    -> rk_o[1407:0], finish_o   (key expansion)
//           rnd_key_i/rnd_state_i   -> rnd_out_o         (one middle round)
//           last_key_i/last_state_i -> last_out_o        (final round)
//           blk_i -> blk_o   (10-cycle pipelined encryption using rk_o)
//  Rev    : 1.0  initial release
// ============================================================================

package aes128_pkg;

  // Forward S-box, row-major: entry 0 occupies the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8].
  // ShiftRows rotates row r left by r, so output (r,c) takes input (r,(c+r)%4).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      // 3*a = xtime(a) ^ a
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// ----------------------------------------------------------------------------
// keyexpansion: one round key per clock after the start edge.
// ----------------------------------------------------------------------------
module keyexpansion (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    key,
  input  logic            start,
  output logic [1407:0]   out,
  output logic            finish
);
  import aes128_pkg::*;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ctr_q, ctr_d;
  logic          finish_q, finish_d;
  logic [127:0]  rk_q [0:10];
  logic [127:0]  rk_d [0:10];

  logic [3:0]    prev_idx;
  logic [127:0]  prev_rk;
  logic [31:0]   t_word, w0_n, w1_n, w2_n, w3_n;

  // Next round key from the previous one (ctr_q is the key being produced).
  always_comb begin
    prev_idx = (ctr_q == 4'd0) ? 4'd0 : ctr_q - 4'd1;
    prev_rk  = rk_q[prev_idx];
    t_word   = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon(ctr_q), 24'h000000};
    w0_n     = prev_rk[127:96] ^ t_word;
    w1_n     = prev_rk[95:64]  ^ w0_n;
    w2_n     = prev_rk[63:32]  ^ w1_n;
    w3_n     = prev_rk[31:0]   ^ w2_n;
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    finish_d = finish_q;
    rk_d     = rk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_d[0] = key;
          ctr_d   = 4'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rk_d[ctr_q] = {w0_n, w1_n, w2_n, w3_n};
        ctr_d       = ctr_q + 4'd1;
        if (ctr_q == 4'd10) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ctr_q    <= 4'd0;
      finish_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      finish_q <= finish_d;
      rk_q     <= rk_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < 11; gi++) begin : g_flat
    assign out[1407-128*gi -: 128] = rk_q[gi];
  end

  assign finish = finish_q;

endmodule

// ----------------------------------------------------------------------------
// round: out <= MixColumns(ShiftRows(SubBytes(state))) ^ key
// ----------------------------------------------------------------------------
module round (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic [127:0]  state,
  output logic [127:0]  out
);
  import aes128_pkg::*;

  logic [127:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= mix_columns(sub_shift(state)) ^ key;
  end

  assign out = out_q;

endmodule

// ----------------------------------------------------------------------------
// lastround: out <= ShiftRows(SubBytes(state)) ^ key
// ----------------------------------------------------------------------------
module lastround (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic [127:0]  state,
  output logic [127:0]  out
);
  import aes128_pkg::*;

  logic [127:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= sub_shift(state) ^ key;
  end

  assign out = out_q;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module aes128_round_units (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    key_i,
  input  logic            start_i,
  output logic [1407:0]   rk_o,
  output logic            finish_o,
  input  logic [127:0]    rnd_key_i,
  input  logic [127:0]    rnd_state_i,
  output logic [127:0]    rnd_out_o,
  input  logic [127:0]    last_key_i,
  input  logic [127:0]    last_state_i,
  output logic [127:0]    last_out_o,
  input  logic [127:0]    blk_i,
  output logic [127:0]    blk_o
);

  logic [1407:0] rk_flat;
  logic [127:0]  chain [0:9];

  keyexpansion u_keyexp (
    .clk    (clk),
    .rst    (rst),
    .key    (key_i),
    .start  (start_i),
    .out    (rk_flat),
    .finish (finish_o)
  );

  round u_round_unit (
    .clk   (clk),
    .rst   (rst),
    .key   (rnd_key_i),
    .state (rnd_state_i),
    .out   (rnd_out_o)
  );

  lastround u_last_unit (
    .clk   (clk),
    .rst   (rst),
    .key   (last_key_i),
    .state (last_state_i),
    .out   (last_out_o)
  );

  // Initial AddRoundKey is folded into the first stage's combinational input.
  assign chain[0] = blk_i ^ rk_flat[1407:1280];

  genvar gr;
  for (gr = 1; gr < 10; gr++) begin : g_rounds
    round u_round (
      .clk   (clk),
      .rst   (rst),
      .key   (rk_flat[1407-128*gr -: 128]),
      .state (chain[gr-1]),
      .out   (chain[gr])
    );
  end

  lastround u_last (
    .clk   (clk),
    .rst   (rst),
    .key   (rk_flat[127:0]),
    .state (chain[9]),
    .out   (blk_o)
  );

  assign rk_o = rk_flat;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_units.sv
`default_nettype none
// ============================================================================
//  Module : tb_aes128_round_units
//  Brief  : Self-checking bench for aes128_round_units. Expected values come
//           from a byte-level AES model built from GF(2^8) arithmetic (S-box
//           derived from multiplicative inverse + affine map) and from the
//           FIPS-197 known-answer vectors.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_aes128_round_units;

  logic            clk;
  logic            rst;
  logic [127:0]    key_i;
  logic            start_i;
  logic [1407:0]   rk_o;
  logic            finish_o;
  logic [127:0]    rnd_key_i, rnd_state_i, rnd_out_o;
  logic [127:0]    last_key_i, last_state_i, last_out_o;
  logic [127:0]    blk_i, blk_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] m_rk   [11];

  aes128_round_units dut (
    .clk          (clk),
    .rst          (rst),
    .key_i        (key_i),
    .start_i      (start_i),
    .rk_o         (rk_o),
    .finish_o     (finish_o),
    .rnd_key_i    (rnd_key_i),
    .rnd_state_i  (rnd_state_i),
    .rnd_out_o    (rnd_out_o),
    .last_key_i   (last_key_i),
    .last_state_i (last_state_i),
    .last_out_o   (last_out_o),
    .blk_i        (blk_i),
    .blk_o        (blk_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %032h exp %032h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] k, input bit last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = sbox_t[a[4*((c+r)%4)+r]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[4*c+r] = last ? b[4*c+r]
                        : gmul(8'h02, b[4*c+r]) ^ gmul(8'h03, b[4*c+(r+1)%4])
                          ^ b[4*c+(r+2)%4] ^ b[4*c+(r+3)%4];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ m_rk[0];
    for (int r = 1; r < 10; r++) s = model_round(s, m_rk[r], 1'b0);
    return model_round(s, m_rk[10], 1'b1);
  endfunction

  // ---------------- stimulus ----------------
  logic [127:0] blocks [$];
  logic [127:0] st_r, k_r, st_l, k_l;

  initial begin
    rst = 1'b1; key_i = '0; start_i = 1'b0;
    rnd_key_i = '0; rnd_state_i = '0; last_key_i = '0; last_state_i = '0; blk_i = '0;
    build_sbox();
    repeat (2) tick();

    // Reset state
    chk("reset_rk0",   rk_o[1407:1280], '0);
    chk("reset_rk10",  rk_o[127:0], '0);
    chk("reset_fin",   128'(finish_o), '0);
    chk("reset_rnd",   rnd_out_o, '0);
    chk("reset_last",  last_out_o, '0);
    chk("reset_blk",   blk_o, '0);
    rst = 1'b0;
    tick();

    // Key expansion KAT with one-cycle start pulse
    key_i = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand_model(key_i);
    start_i = 1'b1;
    tick();                                    // edge 1
    start_i = 1'b0;
    chk("kat_rk0", rk_o[1407:1280], m_rk[0]);
    chk("kat_fin_e1", 128'(finish_o), 128'd0);
    for (int e = 2; e <= 11; e++) begin
      tick();
      chk($sformatf("kat_rk%0d", e-1), rk_o[1407-128*(e-1) -: 128], m_rk[e-1]);
      chk($sformatf("kat_fin_e%0d", e), 128'(finish_o), (e == 11) ? 128'd1 : 128'd0);
    end
    chk("kat_rk1_vec",  rk_o[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_rk10_vec", rk_o[127:0],     128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // New key / start while DONE must not disturb the held keys
    key_i = rnd128();
    start_i = 1'b1;
    repeat (3) tick();
    start_i = 1'b0;
    for (int r = 0; r < 11; r++)
      chk($sformatf("hold_rk%0d", r), rk_o[1407-128*r -: 128], m_rk[r]);
    chk("hold_fin", 128'(finish_o), 128'd1);

    // Round / lastround known answers
    rnd_state_i  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    rnd_key_i    = 128'ha0fafe1788542cb123a339392a6c7605;
    last_state_i = 128'heb40f21e592e38848ba113e71bc342d2;
    last_key_i   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tick();
    chk("round_kat", rnd_out_o,  128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("last_kat",  last_out_o, 128'h3925841d02dc09fbdc118597196a0b32);

    // Random back-to-back inputs, one result per cycle
    for (int n = 0; n < 40; n++) begin
      st_r = rnd128(); k_r = rnd128(); st_l = rnd128(); k_l = rnd128();
      rnd_state_i = st_r; rnd_key_i = k_r; last_state_i = st_l; last_key_i = k_l;
      tick();
      chk($sformatf("round_rand%0d", n), rnd_out_o,  model_round(st_r, k_r, 1'b0));
      chk($sformatf("last_rand%0d", n),  last_out_o, model_round(st_l, k_l, 1'b1));
    end

    // Reset in the middle of an expansion
    rst = 1'b1;
    tick();
    rst = 1'b0;
    key_i = rnd128();
    start_i = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midrst_rk0", rk_o[1407:1280], '0);
    chk("midrst_rk4", rk_o[895:768], '0);
    chk("midrst_fin", 128'(finish_o), '0);
    chk("midrst_rnd", rnd_out_o, '0);
    tick();
    rst = 1'b0;
    key_i = 128'h000102030405060708090a0b0c0d0e0f;
    expand_model(key_i);
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e >= 10) chk($sformatf("restart_fin_e%0d", e), 128'(finish_o), (e == 11) ? 128'd1 : 128'd0);
    end
    start_i = 1'b0;
    chk("restart_rk10", rk_o[127:0], m_rk[10]);
    chk("restart_rk5",  rk_o[1407-128*5 -: 128], m_rk[5]);

    // Full pipelined chain: FIPS-197 vector first, then random blocks
    blocks.push_back(128'h00112233445566778899aabbccddeeff);
    for (int n = 1; n < 16; n++) blocks.push_back(rnd128());
    for (int j = 0; j < 16 + 9; j++) begin
      blk_i = (j < 16) ? blocks[j] : rnd128();
      tick();
      if (j == 9) chk("chain_fips", blk_o, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      if (j >= 9) chk($sformatf("chain_blk%0d", j-9), blk_o, model_encrypt(blocks[j-9]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
